// File: rtl/sum_acc.sv
// sum_acc: batches COUNT consecutive 4-bit sums into one ACC_W-bit total with a
// sticky overflow flag, handed off over valid/ready.
module sum_acc #(
  parameter int COUNT = 5,
  parameter int ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic [ACC_W:0]   sum_s;
  logic             accept_s;

  // Bit ACC_W of the sum is the carry out of the accumulator for this sample.
  assign sum_s    = {1'b0, acc_r} + {{(ACC_W-3){1'b0}}, in_data};
  assign in_ready = (state_r == ACCUM) & ~clr;
  assign accept_s = in_valid & in_ready;

  // Batch accumulation, result register and handshake state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ACCUM;
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      // Abort keeps the last delivered result visible on out_data/out_ovf.
      state_r   <= ACCUM;
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            if (cnt_r == CNT_LAST) begin
              out_data  <= sum_s[ACC_W-1:0];
              out_ovf   <= ovf_r | sum_s[ACC_W];
              out_valid <= 1'b1;
              acc_r     <= '0;
              cnt_r     <= '0;
              ovf_r     <= 1'b0;
              state_r   <= HOLD;
            end else begin
              acc_r <= sum_s[ACC_W-1:0];
              ovf_r <= ovf_r | sum_s[ACC_W];
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ACCUM;
          end
        end
        default: begin
          state_r   <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  sum_acc_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// sum_acc_chk: handshake invariants of sum_acc.
module sum_acc_chk (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic in_ready,
  input logic out_valid,
  input logic out_ready
);

  // A held result only retires through out_ready, clr or rst.
  property p_valid_hold;
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !clr) |=> out_valid;
  endproperty
  a_valid_hold: assert property (p_valid_hold);

  // Input acceptance and result presentation are mutually exclusive.
  property p_no_overlap;
    @(posedge clk) disable iff (rst)
      !(in_ready && out_valid);
  endproperty
  a_no_overlap: assert property (p_no_overlap);

endmodule

// File: tb/tb_sum_acc.sv
// tb_sum_acc: directed and random stimulus for sum_acc, checked against a
// batch-level reference model (queue of accepted samples, totals by arithmetic).
module tb_sum_acc;

  localparam int COUNT = 5;
  localparam int ACC_W = 6;

  logic             clk;
  logic             rst;
  logic             clr;
  logic [3:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  int total;
  int bad;

  // Reference model state.
  int               m_q[$];
  logic             m_valid;
  logic [ACC_W-1:0] m_data;
  logic             m_ovf;

  sum_acc #(.COUNT(COUNT), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, update model at posedge, check outputs.
  task automatic cycle(input logic r, input logic c, input logic v, input logic [3:0] d,
                       input logic ordy, output bit accepted);
    int s;
    @(negedge clk);
    rst = r; clr = c; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk("in_ready", {15'd0, in_ready}, {15'd0, (!m_valid && !c)});
    accepted = v && !m_valid && !c && !r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
    end else if (c) begin
      m_q.delete();
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (ordy) m_valid = 1'b0;
    end else if (v) begin
      m_q.push_back(int'(d));
      if (m_q.size() == COUNT) begin
        s = m_q.sum();
        m_data  = s[ACC_W-1:0];
        m_ovf   = (s >= (1 << ACC_W));
        m_valid = 1'b1;
        m_q.delete();
      end
    end
    #1;
    chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
    chk("out_data", {10'd0, out_data}, {10'd0, m_data});
    chk("out_ovf", {15'd0, out_ovf}, {15'd0, m_ovf});
  endtask

  // Present one sample with in_valid high until the model says it was taken.
  task automatic send(input logic [3:0] d, input logic ordy);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cycle(1'b0, 1'b0, 1'b1, d, ordy, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%0d expected=%0d", n, 20);
    end
  endtask

  task automatic idle(input logic ordy);
    bit acc;
    cycle(1'b0, 1'b0, 1'b0, 4'd0, ordy, acc);
  endtask

  initial begin
    bit acc;
    logic [ACC_W-1:0] held;
    total = 0;
    bad = 0;
    m_valid = 1'b0;
    m_data = '0;
    m_ovf = 1'b0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", {10'd0, out_data}, 16'd0);
    chk("rst_out_ovf", {15'd0, out_ovf}, 16'd0);
    idle(1'b1);

    // Basic batch 1..5.
    for (int i = 1; i <= 5; i++) send(4'(i), 1'b1);
    chk("basic_valid", {15'd0, out_valid}, 16'd1);
    chk("basic_data", {10'd0, out_data}, 16'd15);
    chk("basic_ovf", {15'd0, out_ovf}, 16'd0);
    idle(1'b1);
    chk("basic_one_cycle", {15'd0, out_valid}, 16'd0);

    // Overflow batch, then a clean batch to show the flag clears.
    for (int i = 0; i < 5; i++) send(4'd15, 1'b1);
    chk("ovf_data", {10'd0, out_data}, 16'd11);
    chk("ovf_flag", {15'd0, out_ovf}, 16'd1);
    for (int i = 0; i < 5; i++) send(4'd1, 1'b1);
    chk("ovf_clear_data", {10'd0, out_data}, 16'd5);
    chk("ovf_clear_flag", {15'd0, out_ovf}, 16'd0);

    // Backpressure: stall in HOLD with in_valid high and data 7.
    for (int i = 0; i < 4; i++) send(4'($urandom_range(0, 15)), 1'b1);
    send(4'($urandom_range(0, 15)), 1'b0);
    held = out_data;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, acc);
    chk("bp_stable", {10'd0, out_data}, {10'd0, held});
    cycle(1'b0, 1'b0, 1'b1, 4'd7, 1'b1, acc);
    send(4'd7, 1'b1);
    for (int i = 0; i < 4; i++) send(4'd2, 1'b1);
    chk("bp_next_data", {10'd0, out_data}, 16'd15);

    // Bubbles between samples.
    idle(1'b1);
    for (int i = 0; i < 5; i++) begin
      send(4'd3, 1'b1);
      if (i < 4) begin
        idle(1'b1);
        idle(1'b1);
      end
    end
    chk("bubble_valid", {15'd0, out_valid}, 16'd1);
    chk("bubble_data", {10'd0, out_data}, 16'd15);
    idle(1'b1);

    // Abort mid-batch with a pending sample on the clr cycle.
    for (int i = 0; i < 3; i++) send(4'd9, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, acc);
    for (int i = 0; i < 5; i++) send(4'd1, 1'b1);
    chk("abort_data", {10'd0, out_data}, 16'd5);

    // Reset while holding a result.
    idle(1'b1);
    for (int i = 0; i < 5; i++) send(4'($urandom_range(1, 15)), 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, acc);
    chk("rst_hold_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_hold_data", {10'd0, out_data}, 16'd0);

    // Random traffic with occasional clr and rst.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0), acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_acc.md
# sum_acc

Accumulator stage directly downstream of the 4-bit `adder`. It consumes a stream of 4-bit sums `q` through a valid/ready handshake and adds COUNT consecutive sums into an ACC_W-bit unsigned accumulator. It then presents the total, with a sticky overflow flag, on a valid/ready output port. It converts the adder's per-operation results into one batched total per COUNT operations.

## Interface
- COUNT, default 5: number of samples per batch; legal range 2..15.
- ACC_W, default 6: accumulator and result width in bits; legal range 5..16.

- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous batch abort. Clears the accumulator and count, and returns to ACCUM.
- in_data  in  4  sum from `adder.q`, unsigned.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  ACC_W  batch total, modulo 2^ACC_W.
- out_ovf  out  1  batch total exceeded 2^ACC_W−1.
- out_valid  out  1  out_data and out_ovf are valid.
- out_ready  in  1  consumer takes the result this cycle.

## Operation
- The state machine has two states: ACCUM and HOLD. Reset state is ACCUM.
- Internal registers:
  - acc[ACC_W-1:0]
  - cnt, wide enough to hold COUNT−1
  - ovf (sticky)
- in_ready = (state==ACCUM) & ~clr. This is the only combinational output; all others are registered.
- An input is accepted when in_valid & in_ready are both high at a rising edge.
- ACCUM, accept with cnt < COUNT−1:
  - acc <= acc + zero-extended in_data
  - ovf <= ovf | carry-out of that add
  - cnt <= cnt+1
- ACCUM, accept with cnt == COUNT−1:
  - out_data <= acc + in_data, truncated to ACC_W
  - out_ovf <= ovf | carry
  - out_valid <= 1
  - acc, cnt and ovf clear to 0
  - state <= HOLD
- ACCUM with no accept: all registers hold their values. Gaps in in_valid are allowed and do not count as samples.
- HOLD:
  - in_ready = 0.
  - out_data, out_ovf and out_valid stay stable until out_ready is high at an edge.
  - On that edge, out_valid <= 0 and state <= ACCUM.
- clr, whenever high at an edge:
  - acc, cnt and ovf clear to 0
  - out_valid <= 0
  - state <= ACCUM
  - out_data and out_ovf keep their last values
  - a pending in_valid is dropped, because in_ready is low
- rst overrides clr. At an rst edge, every register clears, in any state, including mid-batch or HOLD.
- Arithmetic is unsigned throughout. Overflow means an accumulated carry out of bit ACC_W−1 at any step of the batch. The output wraps modulo 2^ACC_W.

## Timing
- Reset values:
  - out_data = 0, out_ovf = 0, out_valid = 0
  - in_ready = 1 in the first cycle after reset, provided clr is low
- Latency: the final sample is accepted at edge k, and out_valid is high from edge k, i.e. visible in cycle k+1.
- Throughput: with in_valid and out_ready held high, each batch takes COUNT+1 cycles. That is COUNT accept cycles plus one HOLD cycle.
- The first accept of the next batch occurs no earlier than the edge after the output handshake.
- out_valid never drops without an out_ready handshake, except on rst or clr.
- A sample and its batch result are never accepted or released in the same cycle, since in_ready = 0 in HOLD.
- in_data must be stable while in_valid is high and in_ready is low; the upstream holds it.

## Test plan
All scenarios use COUNT=5, ACC_W=6.
- **Reset:** assert rst for 2 cycles → out_valid=0, out_data=0, out_ovf=0, in_ready=1 on the first cycle after rst drops.
- **Basic batch:** send 1,2,3,4,5 on consecutive cycles with out_ready=1 → out_valid high for exactly 1 cycle after the 5th accept, out_data=15, out_ovf=0, in_ready=0 in that cycle.
- **Overflow:** send 15,15,15,15,15 → out_data=11 (75−64), out_ovf=1. The next batch of 1×5 gives out_data=5, out_ovf=0, which shows the flag cleared.
- **Backpressure with ignored input:**
  - Stimulus: hold out_ready=0 for 3 cycles in HOLD, with in_valid=1 and in_data=7 throughout.
  - Required: out_data stays stable and in_ready=0 during the stall. After out_ready goes high, the next batch starts from acc=0; sending 7 then 2,2,2,2 gives out_data=15.
- **Bubbles:** send samples 3,3,3,3,3 with in_valid low for 2 cycles between each → exactly one result, out_data=15, released 1 cycle after the 5th accept.
- **Abort:**
  - clr after samples 9,9,9, with in_valid high on the clr cycle → sample dropped. Then sending 1,1,1,1,1 gives out_data=5.
  - rst asserted during HOLD → out_valid=0 on the next cycle.
